// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the autobaud controller, the RX pad and uart_rx.
// The controller takes the slave side; the system (or bench) takes the master side.
`ifndef UART_CONFIG_WIDTH_DELAYFRAMES
`define UART_CONFIG_WIDTH_DELAYFRAMES 10
`endif
`ifndef UART_CONFIG_WIDTH
`define UART_CONFIG_WIDTH 15
`endif

interface uart_autobaud_if #(
    parameter int unsigned CFG_W = `UART_CONFIG_WIDTH
);
    logic             start;
    logic             uart_rxpin;
    logic [CFG_W-1:0] settings_in;
    logic [CFG_W-1:0] settings_out;
    logic             rx_rst;
    logic             locked;
    logic             busy;
    logic             error;

    modport master (
        output start, uart_rxpin, settings_in,
        input  settings_out, rx_rst, locked, busy, error
    );

    modport slave (
        input  start, uart_rxpin, settings_in,
        output settings_out, rx_rst, locked, busy, error
    );
endinterface

// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character on the raw RX pin and produces a locked uart_rx
// settings word; DELAYFRAMES occupies the low COUNTER_WIDTH bits of the word.
`ifndef UART_CONFIG_WIDTH_DELAYFRAMES
`define UART_CONFIG_WIDTH_DELAYFRAMES 10
`endif
`ifndef UART_CONFIG_WIDTH
`define UART_CONFIG_WIDTH 15
`endif

module uart_autobaud #(
    parameter int unsigned COUNTER_WIDTH = `UART_CONFIG_WIDTH_DELAYFRAMES,
    parameter int unsigned MEAS_WIDTH    = COUNTER_WIDTH + 4,
    parameter int unsigned IDLE_CYCLES   = 1024,
    parameter int unsigned MIN_PERIOD    = 4
) (
    input logic            clk,
    input logic            rst,
    uart_autobaud_if.slave ab_if
);
    localparam int unsigned CFG_W = `UART_CONFIG_WIDTH;
    localparam int unsigned SEG_W = COUNTER_WIDTH + 1;
    localparam int unsigned QW    = $clog2(IDLE_CYCLES) + 1;
    localparam int unsigned PW    = MEAS_WIDTH + 1;
    localparam logic [PW-1:0] MAX_P = PW'(1) << COUNTER_WIDTH;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_QUIET   = 7'b0000010,
        S_ARMED   = 7'b0000100,
        S_MEASURE = 7'b0001000,
        S_STOPCHK = 7'b0010000,
        S_CHECK   = 7'b0100000,
        S_LOCKED  = 7'b1000000
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q, prev_q, rise_q, fall_q;
    logic [QW-1:0]           qcnt_q, qcnt_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [SEG_W-1:0]        start_len_q, start_len_d;
    logic [MEAS_WIDTH-1:0]   total_q, total_d;
    logic [2:0]              fcnt_q, fcnt_d;
    logic                    first_q, first_d;
    logic [CFG_W-1:0]        cap_q, cap_d;
    logic [CFG_W-1:0]        settings_q, settings_d;
    logic                    locked_q, busy_q, rx_rst_q, error_q, error_d;

    logic [PW-1:0]           total_rnd_c, period_c;
    logic [MEAS_WIDTH-1:0]   start8_c, skew_c;
    logic                    fail_c, edge_c, seg_full_c;

    // Two-flop synchronizer plus a registered edge detector
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= ab_if.uart_rxpin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
            fall_q  <= ~sync2_q & prev_q;
        end
    end

    assign edge_c     = rise_q | fall_q;
    assign seg_full_c = &seg_q;

    // Rounded bit period and start-bit skew, all from registered operands
    always_comb begin
        total_rnd_c = PW'(total_q) + PW'(4);
        period_c    = total_rnd_c >> 3;
        start8_c    = MEAS_WIDTH'(start_len_q) << 3;
        skew_c      = (start8_c >= total_q) ? (start8_c - total_q) : (total_q - start8_c);
        fail_c      = (period_c < PW'(MIN_PERIOD)) || (period_c > MAX_P) ||
                      (skew_c > (total_q >> 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            seg_q       <= '0;
            start_len_q <= '0;
            total_q     <= '0;
            fcnt_q      <= '0;
            first_q     <= 1'b0;
            cap_q       <= '0;
            settings_q  <= '0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
            rx_rst_q    <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            seg_q       <= seg_d;
            start_len_q <= start_len_d;
            total_q     <= total_d;
            fcnt_q      <= fcnt_d;
            first_q     <= first_d;
            cap_q       <= cap_d;
            settings_q  <= settings_d;
            locked_q    <= (state_d == S_LOCKED);
            busy_q      <= (state_d == S_QUIET) || (state_d == S_ARMED) ||
                           (state_d == S_MEASURE) || (state_d == S_STOPCHK) ||
                           (state_d == S_CHECK);
            rx_rst_q    <= (state_d != S_LOCKED);
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        seg_d       = seg_q;
        start_len_d = start_len_q;
        total_d     = total_q;
        fcnt_d      = fcnt_q;
        first_d     = first_q;
        cap_d       = cap_q;
        settings_d  = settings_q;
        error_d     = 1'b0;

        case (state_q)
            S_QUIET: begin
                if (!sync2_q) begin
                    qcnt_d = '0;
                end else if (qcnt_q == QW'(IDLE_CYCLES - 1)) begin
                    state_d = S_ARMED;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            S_ARMED: begin
                if (fall_q) begin
                    state_d = S_MEASURE;
                    seg_d   = SEG_W'(1);
                    total_d = MEAS_WIDTH'(1);
                    fcnt_d  = 3'd1;
                    first_d = 1'b1;
                end
            end
            S_MEASURE: begin
                if (seg_full_c) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (fall_q && (fcnt_q == 3'd4)) begin
                    // Start of the last data bit: total now spans exactly 8 bit periods
                    state_d = S_STOPCHK;
                    seg_d   = SEG_W'(1);
                    fcnt_d  = 3'd5;
                end else begin
                    total_d = total_q + MEAS_WIDTH'(1);
                    if (edge_c) begin
                        seg_d = SEG_W'(1);
                        if (first_q) begin
                            start_len_d = seg_q;
                            first_d     = 1'b0;
                        end
                        if (fall_q) begin
                            fcnt_d = fcnt_q + 3'd1;
                        end
                    end else begin
                        seg_d = seg_q + SEG_W'(1);
                    end
                end
            end
            S_STOPCHK: begin
                if (seg_full_c) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (rise_q) begin
                    state_d = S_CHECK;
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
            end
            S_CHECK: begin
                if (fail_c) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    state_d                        = S_LOCKED;
                    settings_d                     = cap_q;
                    settings_d[COUNTER_WIDTH-1:0]  = COUNTER_WIDTH'(period_c - PW'(1));
                end
            end
            S_IDLE, S_LOCKED: ;
            default: state_d = S_IDLE;
        endcase

        // A start request restarts calibration from any state
        if (ab_if.start) begin
            state_d = S_QUIET;
            cap_d   = ab_if.settings_in;
            qcnt_d  = '0;
            error_d = 1'b0;
        end
    end

    assign ab_if.settings_out = settings_q;
    assign ab_if.rx_rst       = rx_rst_q;
    assign ab_if.locked       = locked_q;
    assign ab_if.busy         = busy_q;
    assign ab_if.error        = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync characters at several rates, bad sync,
// quiet-line gating, timeouts, reset and recalibration.
module tb_uart_autobaud;
    localparam int unsigned CW    = 10;
    localparam int unsigned CFG_W = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_autobaud_if #(.CFG_W(CFG_W)) ab();

    uart_autobaud #(
        .COUNTER_WIDTH(CW),
        .MEAS_WIDTH   (CW + 4),
        .IDLE_CYCLES  (1024),
        .MIN_PERIOD   (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ab_if(ab)
    );

    int n_vec = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int low_cnt = 0;

    always @(negedge clk) begin
        if (ab.error === 1'b1) err_cnt++;
        if (ab.rx_rst === 1'b0) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_set(input logic [4:0] up, input int df);
        logic [9:0] d;
        d = 10'(df);
        return 32'({up, d});
    endfunction

    task automatic hold(input logic v, input int n);
        ab.uart_rxpin = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [4:0] up);
        ab.settings_in = {up, 10'h2AA};
        ab.start = 1'b1;
        @(negedge clk);
        ab.start = 1'b0;
    endtask

    // 0x55 without the stop bit: start bit of length first, then 8 data bits of length p
    task automatic send_sync(input int first, input int p);
        hold(1'b0, first);
        for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 1'b1 : 1'b0, p);
    endtask

    task automatic calibrate(input logic [4:0] up, input int first, input int p);
        err_cnt = 0;
        pulse_start(up);
        hold(1'b1, 1100);
        send_sync(first, p);
        hold(1'b1, p + 12);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_locked"}, 32'(ab.locked), 32'd0);
        chk({tag, "_busy"},   32'(ab.busy),   32'd0);
        chk({tag, "_error"},  32'(ab.error),  32'd0);
        chk({tag, "_rx_rst"}, 32'(ab.rx_rst), 32'd1);
        chk({tag, "_set"},    32'(ab.settings_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ab.start = 1'b1;
        ab.uart_rxpin = 1'b1;
        ab.settings_in = '1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_with_start");
        rst = 1'b0;
        ab.start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(ab.busy), 32'd0);

        // Nominal 16 clk/bit
        calibrate(5'b10101, 16, 16);
        chk("nom_locked", 32'(ab.locked), 32'd1);
        chk("nom_rx_rst", 32'(ab.rx_rst), 32'd0);
        chk("nom_set", 32'(ab.settings_out), exp_set(5'b10101, 15));
        chk("nom_no_err", 32'(err_cnt), 32'd0);
        ab.settings_in = '0;
        repeat (5) @(negedge clk);
        chk("nom_set_stable", 32'(ab.settings_out), exp_set(5'b10101, 15));

        // Start while locked, then recalibrate at 32 clk/bit
        err_cnt = 0;
        pulse_start(5'b01100);
        low_cnt = 0;
        chk("relock_locked", 32'(ab.locked), 32'd0);
        chk("relock_rx_rst", 32'(ab.rx_rst), 32'd1);
        chk("relock_busy",   32'(ab.busy),   32'd1);
        hold(1'b1, 1100);
        send_sync(32, 32);
        chk("recal_rx_rst_high", 32'(low_cnt), 32'd0);
        hold(1'b1, 44);
        chk("recal_locked", 32'(ab.locked), 32'd1);
        chk("recal_set", 32'(ab.settings_out), exp_set(5'b01100, 31));

        // Rounding at 13 clk/bit
        calibrate(5'b00011, 13, 13);
        chk("r13_locked", 32'(ab.locked), 32'd1);
        chk("r13_set", 32'(ab.settings_out), exp_set(5'b00011, 12));

        // 13 clk/bit with +/-1 clock jitter on each edge
        err_cnt = 0;
        pulse_start(5'b11000);
        hold(1'b1, 1100);
        hold(1'b0, 14); hold(1'b1, 11); hold(1'b0, 15); hold(1'b1, 11);
        hold(1'b0, 15); hold(1'b1, 11); hold(1'b0, 15); hold(1'b1, 11);
        hold(1'b0, 13);
        hold(1'b1, 25);
        chk("jit_locked", 32'(ab.locked), 32'd1);
        chk("jit_set", 32'(ab.settings_out), exp_set(5'b11000, 12));
        chk("jit_no_err", 32'(err_cnt), 32'd0);

        // Start bit 24, remaining bits 16: skew check fails
        calibrate(5'b00001, 24, 16);
        chk("bad_err_pulses", 32'(err_cnt), 32'd1);
        chk("bad_locked", 32'(ab.locked), 32'd0);
        chk("bad_rx_rst", 32'(ab.rx_rst), 32'd1);
        chk("bad_busy", 32'(ab.busy), 32'd0);
        chk("bad_set_kept", 32'(ab.settings_out), exp_set(5'b11000, 12));

        // Line toggling every 500 clocks never arms
        err_cnt = 0;
        pulse_start(5'b00111);
        hold(1'b0, 500); hold(1'b1, 500); hold(1'b0, 500); hold(1'b1, 500);
        chk("quiet_busy", 32'(ab.busy), 32'd1);
        chk("quiet_locked", 32'(ab.locked), 32'd0);
        chk("quiet_no_err", 32'(err_cnt), 32'd0);

        // Line stuck low after the falling edge: segment counter timeout
        err_cnt = 0;
        pulse_start(5'b00111);
        hold(1'b1, 1100);
        hold(1'b0, 2200);
        chk("tmo_err_pulses", 32'(err_cnt), 32'd1);
        chk("tmo_busy", 32'(ab.busy), 32'd0);
        chk("tmo_locked", 32'(ab.locked), 32'd0);
        hold(1'b1, 10);

        // 2 clk/bit is below the minimum period
        calibrate(5'b00010, 2, 2);
        chk("min_err_pulses", 32'(err_cnt), 32'd1);
        chk("min_locked", 32'(ab.locked), 32'd0);

        // Reset in the middle of a measurement
        pulse_start(5'b10000);
        hold(1'b1, 1100);
        hold(1'b0, 16);
        hold(1'b1, 5);
        chk("mid_busy", 32'(ab.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        hold(1'b1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Receive-side baud-rate calibration controller that configures `uart_rx`. On a `start` request it holds the receiver in reset, waits for a quiet line, measures one 0x55 sync character on the raw RX pin, and derives the DELAYFRAMES field. It then releases the receiver with a complete, locked settings word. It sits between the RX pad and `uart_rx`, driving that block's `rst` and `settings` inputs.

## Interface

**Parameters**
- `COUNTER_WIDTH`, default `` `UART_CONFIG_WIDTH_DELAYFRAMES ``: width of the DELAYFRAMES field. Each segment counter is `COUNTER_WIDTH+1` bits.
- `MEAS_WIDTH`, default `COUNTER_WIDTH+4`: width of the total-period accumulator.
- `IDLE_CYCLES`, default 1024: consecutive high cycles required before arming.
- `MIN_PERIOD`, default 4: minimum accepted bit period, in clocks.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle request to (re)calibrate.
- `uart_rxpin`, in, 1: raw RX pin. Synchronized internally with 2 flops, initialized to 1.
- `settings_in`, in, `` `UART_CONFIG_WIDTH ``: supplies the parity, stopbits and databits fields. Captured on `start`.
- `settings_out`, out, `` `UART_CONFIG_WIDTH ``: to `uart_rx.settings`.
- `rx_rst`, out, 1: to `uart_rx.rst`. High whenever not locked.
- `locked`, out, 1: calibration valid.
- `busy`, out, 1: calibration in progress.
- `error`, out, 1: one-cycle pulse on a failed calibration.

## Operation

**States (one-hot):** IDLE, QUIET, ARMED, MEASURE, STOPCHK, CHECK, LOCKED.

**Transitions**
- IDLE or LOCKED, `start` → QUIET.
  - Capture `settings_in`.
  - Clear `locked`.
  - Zero the quiet counter.
- QUIET: count consecutive cycles with the synced pin high. A low sample zeroes the count. Count == `IDLE_CYCLES-1` → ARMED.
- ARMED: synced falling edge → MEASURE.
  - Segment counter := 1, total := 1, falling-edge count := 1.
- MEASURE: every cycle, segment counter +1 and total +1.
  - On any synced edge the segment counter restarts at 1.
  - The first edge (end of the start bit) latches the previous segment value as `start_len`.
  - Each falling edge increments the falling count. The 5th falling edge (start of bit 8) → STOPCHK, with total frozen at exactly 8 bit periods.
- STOPCHK: wait for the rising edge (start of the stop bit) → CHECK.
- CHECK, one cycle, combinational compare on registered operands:
  - `p = (total + 4) >> 3`, i.e. rounded bit period.
  - Fail if `p < MIN_PERIOD`.
  - Fail if `p - 1 > 2^COUNTER_WIDTH - 1`.
  - Fail if `|start_len*8 - total| > total >> 2`, i.e. start bit outside ±25 %.
  - Pass → LOCKED:
    - `settings_out` = captured settings with the DELAYFRAMES field := `p - 1` (the `counter_with_strobe` period is reset_value+1).
  - Fail → IDLE and pulse `error`.
- Timeout: in MEASURE or STOPCHK, if the segment counter reaches all-ones → IDLE and pulse `error`.
- `start` in any busy state restarts at QUIET.
- `rst` has priority over everything.

**Outputs**
- `busy` = QUIET | ARMED | MEASURE | STOPCHK | CHECK.
- `rx_rst` = !LOCKED.
- `locked` = LOCKED.
- `settings_out` changes only on entry to LOCKED or on `rst`. It is stable while locked, and `settings_in` changes are ignored until the next `start`.

**Arithmetic**
- All counters are unsigned.
- `start_len*8` is computed at `MEAS_WIDTH`.
- The accumulator cannot overflow before the segment-counter timeout fires.

## Timing

**Reset values**
- State IDLE.
- `settings_out` = 0, `locked` = 0, `busy` = 0, `error` = 0, `rx_rst` = 1.
- Synchronizer = 1.

**Latencies**
- Pin to internal edge detect: 2 clocks (synchronizer) plus 1 clock (edge register).
- CHECK occupies exactly 1 cycle.
- `locked` rise, `rx_rst` fall and the `settings_out` update all occur on the same edge, the first edge after CHECK.
- `error` is high for exactly 1 cycle, coincident with entry to IDLE.

**Boundary conditions**
- `start` on the same cycle as `rst`: reset wins.
- `start` while LOCKED: `locked` and `rx_rst` change on the next edge.
- Glitch shorter than 1 clock after synchronization: counted as a segment and caught by the ±25 % or timeout check.

## Test plan

- **Nominal:** `settings_in` parity=none, 8N1. `start`, line high 1100 clocks, 0x55 at 16 clk/bit → `locked`=1, DELAYFRAMES=15, `rx_rst`=0, `error` never high. Then feed 0xA3 to a connected `uart_rx` → `dataout`=0xA3.
- **Rounding:** 0x55 at 13 clk/bit (total 104) → DELAYFRAMES=12. With edge jitter of ±1 clock per edge → still 12.
- **Quiet requirement:** line toggles every 500 clocks after `start` → stays in QUIET, `busy`=1, no `locked`.
- **Bad sync:** start bit 24 clocks, remaining bits 16 clocks (|192-136|=56 > 34) → `error` pulse, IDLE, `locked`=0, `rx_rst`=1.
- **Timeout and minimum:**
  - Line stuck low after the falling edge → `error` when the segment counter saturates.
  - 0x55 at 2 clk/bit with `MIN_PERIOD`=4 → `error`.
- **Reset and restart:**
  - `rst` mid-MEASURE → all outputs at reset values next cycle.
  - `start` while LOCKED at 16 clk/bit, then recalibrate at 32 clk/bit → DELAYFRAMES=31, `rx_rst` high throughout the recalibration.
